// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Purpose  : SPI responder that oversamples sclk/mosi/ss_n in the system
//             clock domain. Each ss_n-framed word is deserialised MSB-first
//             onto o_rx_data while i_tx_data is serialised onto o_miso.
//             All four SPI modes are supported, selected per frame.
//  Ports    : i_clk, i_reset    - system clock, synchronous active-high reset
//             i_cpol, i_cpha    - SPI mode, latched when ss_n falls
//             i_tx_data         - word returned to the master, captured at
//                                 frame start and at every reload point
//             o_rx_data         - last completely received word
//             o_rx_valid        - 1-cycle pulse when o_rx_data updates
//             o_tx_next         - 1-cycle pulse alongside o_rx_valid
//             o_frame_err       - 1-cycle pulse when ss_n rises mid-word
//             o_busy            - high while a frame is selected
//             i_sclk, i_mosi,
//             i_ss_n            - asynchronous SPI pins from the master
//             o_miso, o_miso_oe - SPI data to the master and pad enable
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx_next,
  output logic                  o_frame_err,
  output logic                  o_busy,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss_n,
  output logic                  o_miso,
  output logic                  o_miso_oe
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  // Sync flops reset to 1 so that an idle bus (ss_n high) never looks like a
  // select edge when reset is released.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sclk_sync <= '1;
      r_mosi_sync <= '1;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b1;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_ss_s;
  logic w_sclk_edge;
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_ss_fall;
  logic w_ss_rise;

  // Mode bits used for the running frame (latched at ss_n fall)
  logic r_cpol;
  logic r_cpha;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_edge = w_sclk_s ^ r_sclk_d;
  // Leading edge leaves the idle level, trailing edge returns to it.
  assign w_lead      = w_sclk_edge & (w_sclk_s != r_cpol);
  assign w_trail     = w_sclk_edge & (w_sclk_s == r_cpol);
  assign w_sample    = r_cpha ? w_trail : w_lead;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;

  // --------------------------------------------------------------------------
  // Frame state machine and datapath
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-2:0] r_rx_shift;   // bits received so far in this word
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_tx_next;
  logic                  r_frame_err;
  logic                  r_busy;
  logic                  r_miso;

  logic [DATA_WIDTH-1:0] w_rx_word;
  assign w_rx_word = {r_rx_shift, w_mosi_s};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_next   <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_tx_next   <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_cpol     <= i_cpol;
            r_cpha     <= i_cpha;
            r_tx_shift <= i_tx_data;
            // For cpha=0 the first bit must be on miso before the first edge.
            r_miso     <= i_tx_data[DATA_WIDTH-1];
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          // Deselect takes priority over any sclk edge seen in the same cycle.
          if (w_ss_rise) begin
            if (r_bit_cnt != '0) begin
              r_frame_err <= 1'b1;
            end
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_miso    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_word[DATA_WIDTH-2:0];
              if (r_bit_cnt == C_LAST_BIT) begin
                r_bit_cnt  <= '0;
                r_rx_data  <= w_rx_word;
                r_rx_valid <= 1'b1;
                r_tx_next  <= 1'b1;
                // cpha=1 shifts on the leading edge, so the next word must
                // already be in place before the following leading edge.
                if (r_cpha) begin
                  r_tx_shift <= i_tx_data;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end

            // cpha=0: shift on trailing edge; the trailing edge right after
            // a completed word reloads from i_tx_data instead.
            if (!r_cpha && w_trail) begin
              if (r_bit_cnt == '0) begin
                r_tx_shift <= i_tx_data;
                r_miso     <= i_tx_data[DATA_WIDTH-1];
              end else begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                r_miso     <= r_tx_shift[DATA_WIDTH-2];
              end
            end

            // cpha=1: present the next bit on the leading edge.
            if (r_cpha && w_lead) begin
              r_miso     <= r_tx_shift[DATA_WIDTH-1];
              r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_tx_next   = r_tx_next;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;
  assign o_miso      = r_miso;
  assign o_miso_oe   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Purpose  : Self-checking bench for spi_slave. A behavioural SPI master
//             drives the pins; received words are predicted into a
//             scoreboard queue and checked by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int HP   = 8;    // sclk half period in clk cycles

  logic          clk;
  logic          reset;
  logic          cpol_in;
  logic          cpha_in;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_next;
  logic          frame_err;
  logic          busy;
  logic          sclk;
  logic          mosi;
  logic          ss_n;
  logic          miso;
  logic          miso_oe;

  spi_slave #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cpol      (cpol_in),
    .i_cpha      (cpha_in),
    .i_tx_data   (tx_data),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .o_tx_next   (tx_next),
    .o_frame_err (frame_err),
    .o_busy      (busy),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_ss_n      (ss_n),
    .o_miso      (miso),
    .o_miso_oe   (miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t          rx_q[$];
  int            err_exp  = 0;
  int            n_checks = 0;
  int            n_errs   = 0;
  logic [DW-1:0] last_rx  = '0;     // model of o_rx_data
  logic [DW-1:0] mosi_w[4];
  logic [DW-1:0] miso_w[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compares every DUT pulse against the scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rx_valid || tx_next) begin
      check("tx_next_with_rx_valid", {31'b0, tx_next}, {31'b0, rx_valid});
    end
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        check("unexpected_rx_valid", {24'b0, rx_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = rx_q.pop_front();
        check("rx_data", {24'b0, rx_data}, {24'b0, e.d});
        check("rx_latency_cycle", cyc, e.c);
      end
    end
    if (frame_err) begin
      check("frame_err_expected", {31'b0, (err_exp > 0)}, 32'd1);
      if (err_exp > 0) err_exp--;
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural SPI master. Sends mosi_w[0..nw-1], expects miso_w[] back.
  // The last word carries nb_last bits; end_ss releases ss_n afterwards.
  // --------------------------------------------------------------------------
  task automatic spi_xfer(input logic pol, input logic pha, input int nw,
                          input int nb_last, input bit end_ss);
    logic [DW-1:0] rd;
    int            nb;
    cpol_in = pol;
    cpha_in = pha;
    tx_data = miso_w[0];
    sclk    = pol;
    tick(4);
    ss_n = 1'b0;
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? nb_last : DW;
      rd = '0;
      for (int b = 0; b < nb; b++) begin
        if (!pha) begin
          mosi = mosi_w[w][DW-1-b];
          tick(HP);
          sclk = ~pol;
          rd   = {rd[DW-2:0], miso};
          if (b == DW - 1) rx_q.push_back('{d: mosi_w[w], c: cyc + SYNC + 1});
          if (w == 0 && b == 0) begin
            check("busy_in_frame", {31'b0, busy}, 32'd1);
            check("miso_oe_in_frame", {31'b0, miso_oe}, 32'd1);
          end
          if (b == 0 && w + 1 < nw) tx_data = miso_w[w+1];
          tick(HP);
          sclk = pol;
        end else begin
          tick(HP);
          sclk = ~pol;
          mosi = mosi_w[w][DW-1-b];
          if (w == 0 && b == 0) begin
            check("busy_in_frame", {31'b0, busy}, 32'd1);
            check("miso_oe_in_frame", {31'b0, miso_oe}, 32'd1);
          end
          if (b == 0 && w + 1 < nw) tx_data = miso_w[w+1];
          tick(HP);
          sclk = pol;
          rd   = {rd[DW-2:0], miso};
          if (b == DW - 1) rx_q.push_back('{d: mosi_w[w], c: cyc + SYNC + 1});
        end
      end
      if (nb == DW) begin
        check("master_read_miso", {24'b0, rd}, {24'b0, miso_w[w]});
        last_rx = mosi_w[w];
      end
    end
    tick(HP);
    if (end_ss) begin
      if (nb_last != DW) err_exp++;
      ss_n = 1'b1;
      tick(HP);
      check("busy_after_frame", {31'b0, busy}, 32'd0);
      check("miso_after_frame", {31'b0, miso}, 32'd0);
      check("rx_data_held", {24'b0, rx_data}, {24'b0, last_rx});
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset   = 1'b1;
    cpol_in = 1'b0;
    cpha_in = 1'b0;
    tx_data = '0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    ss_n    = 1'b1;

    // Reset state, then sclk activity while deselected must stay invisible
    tick(3);
    check("reset_rx_data", {24'b0, rx_data}, 32'd0);
    check("reset_pulses", {29'b0, rx_valid, tx_next, frame_err}, 32'd0);
    check("reset_busy_oe", {30'b0, busy, miso_oe}, 32'd0);
    check("reset_miso", {31'b0, miso}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      tick(HP);
      check("idle_miso_busy", {30'b0, miso, busy}, 32'd0);
    end
    sclk = 1'b0;
    tick(4);

    // Mode 0 single word
    mosi_w[0] = 8'hA5; miso_w[0] = 8'h3C;
    spi_xfer(1'b0, 1'b0, 1, DW, 1'b1);

    // Mode 3, two words back to back
    mosi_w[0] = 8'h12; miso_w[0] = 8'h81;
    mosi_w[1] = 8'h34; miso_w[1] = 8'h7E;
    spi_xfer(1'b1, 1'b1, 2, DW, 1'b1);

    // Mode 1 aborted after 3 bits
    mosi_w[0] = 8'hF0; miso_w[0] = 8'h0F;
    spi_xfer(1'b0, 1'b1, 1, 3, 1'b1);

    // Mode 2 with cpol input flipped mid-frame; next frame uses mode 0
    mosi_w[0] = 8'hC3; miso_w[0] = 8'h96;
    fork
      spi_xfer(1'b1, 1'b0, 1, DW, 1'b1);
      begin
        tick(40);
        cpol_in = 1'b0;
      end
    join
    mosi_w[0] = 8'h69; miso_w[0] = 8'hE1;
    spi_xfer(1'b0, 1'b0, 1, DW, 1'b1);

    // Reset in the middle of a frame: silent abort
    mosi_w[0] = 8'hFF; miso_w[0] = 8'hAA;
    spi_xfer(1'b0, 1'b0, 1, 5, 1'b0);
    reset = 1'b1;
    tick(3);
    check("midreset_rx_data", {24'b0, rx_data}, 32'd0);
    check("midreset_busy_miso", {30'b0, busy, miso}, 32'd0);
    last_rx = '0;
    ss_n    = 1'b1;
    sclk    = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(6);
    mosi_w[0] = 8'h55; miso_w[0] = 8'h5A;
    spi_xfer(1'b0, 1'b0, 1, DW, 1'b1);

    // Randomised frames, some aborted mid-word
    for (int f = 0; f < 12; f++) begin
      int nw;
      int nb;
      nw = $urandom_range(1, 3);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : DW;
      for (int w = 0; w < nw; w++) begin
        mosi_w[w] = DW'($urandom);
        miso_w[w] = DW'($urandom);
      end
      spi_xfer(1'($urandom), 1'($urandom), nw, nb, 1'b1);
    end

    tick(20);
    check("scoreboard_drained", rx_q.size(), 32'd0);
    check("frame_err_all_seen", err_exp, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
